apb_follower: RTL and testbench

APB_FOLLOWER -- requirements
Module: apb_follower

---
 rtl/apb_pkg.sv | 14 +
 rtl/apb_regfile.sv | 50 +++++
 rtl/apb_follower.sv | 173 +++++++++++++++++
 tb/tb_apb_follower.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB follower and its register file.
package apb_pkg;

    localparam logic [15:0] APB_ID     = 16'hA5B0;
    localparam int          WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_ACCESS = 2'd3
    } apb_state_e;

endpackage

// File: rtl/apb_regfile.sv
// Word register file: synchronous write, combinational read, index 0 is a read-only ID.
module apb_regfile
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int                    IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH-1:0] NUM_A  = ADDR_WIDTH'(NUM_REGS);

    logic [DATA_WIDTH-1:0] regs_r [1:NUM_REGS-1];
    logic                  in_range_s;
    logic [IDX_W-1:0]      idx_s;

    assign in_range_s = (addr < NUM_A);
    assign idx_s      = addr[IDX_W-1:0];

    // Register storage; slot 0 has no flops and silently drops writes.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
        end else if (wr_en && in_range_s && (addr != '0)) begin
            regs_r[idx_s] <= wr_data;
        end
    end

    // Read mux with the fixed ID at index 0 and zero outside the map.
    always_comb begin
        rd_data = '0;
        if (addr == '0) begin
            rd_data = DATA_WIDTH'(APB_ID);
        end else if (in_range_s) begin
            rd_data = regs_r[idx_s];
        end else begin
            rd_data = '0;
        end
    end

endmodule

// File: rtl/apb_follower.sv
// APB follower with a small register map and optional wait states.
// Wait-state logic is built only when APB_FOLLOWER_WAIT_EN is defined.
module apb_follower
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PREADY,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PSLVERR
);

    localparam logic [ADDR_WIDTH-1:0] NUM_A = ADDR_WIDTH'(NUM_REGS);
`ifdef APB_FOLLOWER_WAIT_EN
    localparam int                    EFF_WAIT  = WAIT_CYCLES;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);
`else
    // Wait states compiled out; WAIT_CYCLES stays in the parameter list for a uniform interface.
    localparam int                    EFF_WAIT  = 0 * WAIT_CYCLES;
`endif

    apb_state_e            state_r, state_nxt_s;
    logic [ADDR_WIDTH-1:0] addr_r, xfer_addr_s;
    logic                  write_r, xfer_write_s;
    logic [DATA_WIDTH-1:0] wdata_r, rd_data_s, prdata_s, prdata_r;
    logic                  err_s, wr_en_s, pready_s, pslverr_s, pready_r, pslverr_r;
`ifdef APB_FOLLOWER_WAIT_EN
    logic [WAIT_CNT_W-1:0] wait_cnt_r, wait_cnt_s;

    // Wait-state down-counter.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wait_cnt_r <= '0;
        end else begin
            wait_cnt_r <= wait_cnt_s;
        end
    end
`endif

    // State register.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; leaving SETUP/WAIT early is an abort.
    always_comb begin
        state_nxt_s = state_r;
`ifdef APB_FOLLOWER_WAIT_EN
        wait_cnt_s  = wait_cnt_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_nxt_s = ST_SETUP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (!PSEL) begin
                    state_nxt_s = ST_IDLE;
                end else if (EFF_WAIT > 32'sd0) begin
                    state_nxt_s = ST_WAIT;
`ifdef APB_FOLLOWER_WAIT_EN
                    wait_cnt_s  = WAIT_LOAD;
`endif
                end else begin
                    state_nxt_s = ST_ACCESS;
                end
            end
`ifdef APB_FOLLOWER_WAIT_EN
            ST_WAIT: begin
                if (!PSEL || !PENABLE) begin
                    state_nxt_s = ST_IDLE;
                    wait_cnt_s  = '0;
                end else if (wait_cnt_r == WAIT_CNT_W'(1)) begin
                    state_nxt_s = ST_ACCESS;
                    wait_cnt_s  = wait_cnt_r - WAIT_CNT_W'(1);
                end else begin
                    state_nxt_s = ST_WAIT;
                    wait_cnt_s  = wait_cnt_r - WAIT_CNT_W'(1);
                end
            end
`endif
            ST_ACCESS: state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // Transfer attributes: live bus during SETUP, captured copy afterwards.
    always_comb begin
        if (state_r == ST_SETUP) begin
            xfer_addr_s  = PADDR;
            xfer_write_s = PWRITE;
        end else begin
            xfer_addr_s  = addr_r;
            xfer_write_s = write_r;
        end
    end

    assign err_s   = (xfer_addr_s >= NUM_A) || (xfer_write_s && (xfer_addr_s == '0));
    assign wr_en_s = (state_r == ST_ACCESS) && PSEL && PENABLE && write_r && !err_s;

    // Capture of the transfer in SETUP.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            addr_r  <= '0;
            write_r <= 1'b0;
            wdata_r <= '0;
        end else if (state_r == ST_SETUP) begin
            addr_r  <= PADDR;
            write_r <= PWRITE;
            wdata_r <= PWDATA;
        end
    end

    apb_regfile #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_regfile (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .wr_en   (wr_en_s),
        .addr    (xfer_addr_s),
        .wr_data (wdata_r),
        .rd_data (rd_data_s)
    );

    // Response values for the cycle about to start; nonzero only entering ACCESS.
    always_comb begin
        pready_s  = (state_nxt_s == ST_ACCESS);
        pslverr_s = pready_s && err_s;
        prdata_s  = '0;
        if (pready_s && !xfer_write_s && !err_s) begin
            prdata_s = rd_data_s;
        end else begin
            prdata_s = '0;
        end
    end

    // Registered bus outputs.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
            prdata_r  <= '0;
        end else begin
            pready_r  <= pready_s;
            pslverr_r <= pslverr_s;
            prdata_r  <= prdata_s;
        end
    end

    assign PREADY  = pready_r;
    assign PSLVERR = pslverr_r;
    assign PRDATA  = prdata_r;

endmodule

// File: tb/tb_apb_follower.sv
// Self-checking bench for apb_follower against a register-map reference model.
module tb_apb_follower;

    localparam int AW = 10;
    localparam int DW = 16;
    localparam int NR = 16;
    localparam int OW = DW + 2;
`ifdef APB_FOLLOWER_WAIT_EN
    localparam int W = 2;
`else
    localparam int W = 0;
`endif

    logic          PCLK = 1'b0;
    logic          PRESET, PSEL, PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA;
    logic          PREADY, PSLVERR;

    int            vectors     = 0;
    int            miscompares = 0;
    logic [DW-1:0] mdl [NR];

    apb_follower #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .NUM_REGS    (NR),
        .WAIT_CYCLES (2)
    ) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PADDR   (PADDR),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PWDATA  (PWDATA),
        .PREADY  (PREADY),
        .PRDATA  (PRDATA),
        .PSLVERR (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed {rdy,err,data}=%h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_err(input bit wr, input logic [AW-1:0] a);
        return (a >= AW'(NR)) || (wr && (a == '0));
    endfunction

    function automatic logic [DW-1:0] rd_val(input bit wr, input logic [AW-1:0] a);
        if (wr || is_err(wr, a)) return '0;
        if (a == '0) return 16'hA5B0;
        return mdl[a[3:0]];
    endfunction

    function automatic logic [OW-1:0] outs();
        return {PREADY, PSLVERR, PRDATA};
    endfunction

    // ev: 0 = none, 1 = drop PSEL in cycle T0+ev_cyc, 2 = reset in cycle T0+ev_cyc
    task automatic xfer(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int ev, input int ev_cyc, input string tag);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
        chk({tag, "/setup"}, outs(), '0);
        step();
        PENABLE = 1'b1;
        chk({tag, "/t0"}, outs(), '0);
        step();
        for (int c = 1; c <= W + 1; c++) begin
            if (ev == 1 && c == ev_cyc) begin
                PSEL = 1'b0;
                step();
                PSEL = 1'b1;
                for (int k = 0; k < W + 2; k++) begin
                    chk({tag, "/abort_idle"}, outs(), '0);
                    step();
                end
                PSEL = 1'b0; PENABLE = 1'b0;
                return;
            end
            if (ev == 2 && c == ev_cyc) begin
                PRESET = 1'b1;
                step();
                PRESET = 1'b0;
                for (int i = 0; i < NR; i++) mdl[i] = '0;
                chk({tag, "/after_reset"}, outs(), '0);
                PSEL = 1'b0; PENABLE = 1'b0;
                return;
            end
            PADDR  = AW'($urandom);
            PWDATA = DW'($urandom);
            PWRITE = 1'($urandom);
            if (c <= W) begin
                chk({tag, "/wait"}, outs(), '0);
            end else begin
                chk({tag, "/access"}, outs(), {1'b1, is_err(wr, a), rd_val(wr, a)});
                if (wr && !is_err(wr, a)) mdl[a[3:0]] = d;
            end
            step();
        end
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic readback(input string tag);
        for (int i = 0; i < NR; i++) xfer(1'b0, AW'(i), '0, 0, 0, tag);
    endtask

    initial begin
        logic [AW-1:0] ra;
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0;
        for (int i = 0; i < NR; i++) mdl[i] = '0;
        step();
        step();
        chk("reset", outs(), '0);
        PRESET = 1'b0;

        // PSEL with PENABLE already high must not start a transfer
        PSEL = 1'b1; PENABLE = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("idle_ignore", outs(), '0);
        end
        PSEL = 1'b0; PENABLE = 1'b0;
        step();

        xfer(1'b1, 10'd3, 16'h1234, 0, 0, "wr3");
        step();
        xfer(1'b0, 10'd3, 16'h0000, 0, 0, "rd3");
        xfer(1'b0, 10'd0, 16'h0000, 0, 0, "rd_id");
        xfer(1'b1, 10'd0, 16'hFFFF, 0, 0, "wr_id");
        xfer(1'b0, 10'd0, 16'h0000, 0, 0, "rd_id2");
        xfer(1'b1, 10'd20, 16'hDEAD, 0, 0, "wr_oor");
        xfer(1'b0, 10'd20, 16'h0000, 0, 0, "rd_oor");
        readback("rb1");

`ifdef APB_FOLLOWER_WAIT_EN
        xfer(1'b1, 10'd7, 16'hBEEF, 0, 0, "wr7");
        xfer(1'b1, 10'd7, 16'h5555, 1, 1, "abort7");
        xfer(1'b0, 10'd7, 16'h0000, 0, 0, "rd7");
        xfer(1'b1, 10'd5, 16'h0F0F, 0, 0, "wr5");
        xfer(1'b1, 10'd5, 16'h7777, 2, 2, "rst5");
        xfer(1'b0, 10'd5, 16'h0000, 0, 0, "rd5");
        xfer(1'b0, 10'd7, 16'h0000, 0, 0, "rd7_rst");
`else
        xfer(1'b1, 10'd1, 16'hA1A1, 0, 0, "b2b_wr1");
        xfer(1'b1, 10'd2, 16'hB2B2, 0, 0, "b2b_wr2");
        xfer(1'b0, 10'd1, 16'h0000, 0, 0, "b2b_rd1");
        xfer(1'b0, 10'd2, 16'h0000, 0, 0, "b2b_rd2");
`endif

        for (int n = 0; n < 40; n++) begin
            ra = AW'($urandom_range(20, 0));
            xfer(1'($urandom), ra, DW'($urandom), 0, 0, "rand");
            if ($urandom_range(3, 0) == 0) begin
                step();
                chk("rand_idle", outs(), '0);
            end
        end
        readback("rb2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
